// File: rtl/vend_pkg.sv
// Shared types and constants for the vending coin datapath.
// Coin codes match the coin-input FSM encoding; values are in nickel units.
package vend_pkg;

    typedef enum logic [1:0] {
        NICKEL  = 2'b00,
        DIME    = 2'b01,
        QUARTER = 2'b10,
        NONE    = 2'b11
    } coin_sel_e;

    typedef enum logic [1:0] {
        StCollect = 2'b00,
        StVend    = 2'b01,
        StChange  = 2'b10
    } disp_state_e;

    localparam int unsigned CoinValW = 3;

    localparam logic [CoinValW-1:0] NickelVal  = 3'd1;
    localparam logic [CoinValW-1:0] DimeVal    = 3'd2;
    localparam logic [CoinValW-1:0] QuarterVal = 3'd5;

endpackage

// File: rtl/vend_coin_decode.sv
// Coin edge detector: flags a coin code that is new relative to the previous cycle
// and looks up its value in nickel units.
module vend_coin_decode
    import vend_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  coin_sel_e           coin_sel,
    output logic                coin_valid,
    output logic [CoinValW-1:0] coin_value
);

    coin_sel_e prev_sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sel_q <= NONE;
        end else begin
            prev_sel_q <= coin_sel;
        end
    end

    always_comb begin
        coin_valid = (coin_sel != NONE) && (coin_sel != prev_sel_q);
        coin_value = '0;
        case (coin_sel)
            NICKEL:  coin_value = NickelVal;
            DIME:    coin_value = DimeVal;
            QUARTER: coin_value = QuarterVal;
            default: coin_value = '0;
        endcase
    end

endmodule

// File: rtl/vend_change_dispenser.sv
// Credit accumulator, vend strobe and largest-first change/refund dispenser.
// All outputs decode from registered state so inputs never reach outputs combinationally.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned PRICE_NICKELS = 13,
    parameter int unsigned CREDIT_W      = 6
) (
    input  logic                i_clk,
    input  logic                ni_rst,
    input  logic [1:0]          i_coin_sel,
    input  logic                i_cancel,
    output logic                o_vend,
    output logic                o_nickel,
    output logic                o_dime,
    output logic                o_quarter,
    output logic                o_busy,
    output logic                o_reject,
    output logic [CREDIT_W-1:0] o_credit
);

    localparam logic [CREDIT_W-1:0] Price = CREDIT_W'(PRICE_NICKELS);

    disp_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;

    logic                coin_valid;
    logic [CoinValW-1:0] coin_value;
    logic [CREDIT_W-1:0] coin_sum;
    logic [CREDIT_W-1:0] change_val;
    logic                pay_quarter, pay_dime, pay_nickel, busy;

    vend_coin_decode u_coin_decode (
        .clk        (i_clk),
        .rst_n      (ni_rst),
        .coin_sel   (coin_sel_e'(i_coin_sel)),
        .coin_valid (coin_valid),
        .coin_value (coin_value)
    );

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            state_q  <= StCollect;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    // Coin selection for the current change cycle, largest denomination first.
    always_comb begin
        busy        = (state_q == StVend) || (state_q == StChange);
        pay_quarter = (state_q == StChange) && (credit_q >= CREDIT_W'(QuarterVal));
        pay_dime    = (state_q == StChange) && !pay_quarter
                      && (credit_q >= CREDIT_W'(DimeVal));
        pay_nickel  = (state_q == StChange) && (credit_q == CREDIT_W'(NickelVal));
        change_val  = '0;
        if (pay_quarter) begin
            change_val = CREDIT_W'(QuarterVal);
        end else if (pay_dime) begin
            change_val = CREDIT_W'(DimeVal);
        end else if (pay_nickel) begin
            change_val = CREDIT_W'(NickelVal);
        end
        coin_sum = credit_q + (coin_valid ? CREDIT_W'(coin_value) : '0);
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = busy && coin_valid;
        unique case (state_q)
            StCollect: begin
                credit_d = coin_sum;
                // Cancel takes priority over a price-reaching coin in the same cycle.
                if (i_cancel && (coin_sum != '0)) begin
                    state_d = StChange;
                end else if (coin_sum >= Price) begin
                    state_d = StVend;
                end
            end
            StVend: begin
                credit_d = credit_q - Price;
                state_d  = (credit_d != '0) ? StChange : StCollect;
            end
            StChange: begin
                credit_d = credit_q - change_val;
                if (credit_d == '0) begin
                    state_d = StCollect;
                end
            end
            default: begin
                state_d  = StCollect;
                credit_d = '0;
            end
        endcase
    end

    always_comb begin
        o_vend    = (state_q == StVend);
        o_nickel  = pay_nickel;
        o_dime    = pay_dime;
        o_quarter = pay_quarter;
        o_busy    = busy;
        o_reject  = reject_q;
        o_credit  = credit_q;
    end

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed self-checking bench for the coin dispenser: each step applies inputs,
// clocks once and compares every output against hand-computed values.
module tb_vend_change_dispenser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] coin_sel;
    logic       cancel;
    logic       vend, nickel, dime, quarter, busy, reject;
    logic [5:0] credit;

    int vectors     = 0;
    int miscompares = 0;

    vend_change_dispenser #(
        .PRICE_NICKELS (13),
        .CREDIT_W      (6)
    ) dut (
        .i_clk      (clk),
        .ni_rst     (rst_n),
        .i_coin_sel (coin_sel),
        .i_cancel   (cancel),
        .o_vend     (vend),
        .o_nickel   (nickel),
        .o_dime     (dime),
        .o_quarter  (quarter),
        .o_busy     (busy),
        .o_reject   (reject),
        .o_credit   (credit)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic v, input logic n, input logic d,
                       input logic q, input logic b, input logic r, input logic [5:0] c);
        logic [11:0] obs, exp;
        obs = {vend, nickel, dime, quarter, busy, reject, credit};
        exp = {v, n, d, q, b, r, c};
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: got vend/nk/dm/qt/busy/rej=%b%b%b%b%b%b credit=%0d, want %b%b%b%b%b%b credit=%0d",
                   tag, obs[11], obs[10], obs[9], obs[8], obs[7], obs[6], obs[5:0],
                   exp[11], exp[10], exp[9], exp[8], exp[7], exp[6], exp[5:0]);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        coin_sel = 2'b11;
        cancel   = 1'b0;
        step();
        step();
        chk("reset", 0, 0, 0, 0, 0, 0, 6'd0);
        rst_n = 1'b1;
        step();
        chk("idle", 0, 0, 0, 0, 0, 0, 6'd0);

        // Held quarter counts once.
        coin_sel = 2'b10; step(); chk("held_q1", 0, 0, 0, 0, 0, 0, 6'd5);
        step();               chk("held_q2", 0, 0, 0, 0, 0, 0, 6'd5);
        step();               chk("held_q3", 0, 0, 0, 0, 0, 0, 6'd5);
        step();               chk("held_q4", 0, 0, 0, 0, 0, 0, 6'd5);
        coin_sel = 2'b11; step(); chk("held_rel", 0, 0, 0, 0, 0, 0, 6'd5);

        // Cancel refunds the 5 as one quarter.
        cancel = 1'b1; step(); chk("cancel5", 0, 0, 0, 1, 1, 0, 6'd5);
        cancel = 1'b0; step(); chk("cancel5_done", 0, 0, 0, 0, 0, 0, 6'd0);

        // Cancel with zero credit is ignored.
        cancel = 1'b1; step(); chk("cancel_zero", 0, 0, 0, 0, 0, 0, 6'd0);
        cancel = 1'b0;

        // Back-to-back quarter then dime.
        coin_sel = 2'b10; step(); chk("b2b_q", 0, 0, 0, 0, 0, 0, 6'd5);
        coin_sel = 2'b01; step(); chk("b2b_d", 0, 0, 0, 0, 0, 0, 6'd7);
        coin_sel = 2'b11; step(); chk("b2b_rel", 0, 0, 0, 0, 0, 0, 6'd7);

        // Exact price: 7 + 5 + 1 = 13, vend with no change.
        coin_sel = 2'b10; step(); chk("exact_q", 0, 0, 0, 0, 0, 0, 6'd12);
        coin_sel = 2'b11; step(); chk("exact_gap", 0, 0, 0, 0, 0, 0, 6'd12);
        coin_sel = 2'b00; step(); chk("exact_vend", 1, 0, 0, 0, 1, 0, 6'd13);
        coin_sel = 2'b11; step(); chk("exact_done", 0, 0, 0, 0, 0, 0, 6'd0);

        // Three quarters: vend then one dime of change.
        coin_sel = 2'b10; step(); chk("qqq_1", 0, 0, 0, 0, 0, 0, 6'd5);
        coin_sel = 2'b11; step();
        coin_sel = 2'b10; step(); chk("qqq_2", 0, 0, 0, 0, 0, 0, 6'd10);
        coin_sel = 2'b11; step();
        coin_sel = 2'b10; step(); chk("qqq_vend", 1, 0, 0, 0, 1, 0, 6'd15);
        coin_sel = 2'b11; step(); chk("qqq_dime", 0, 0, 1, 0, 1, 0, 6'd2);
        step();               chk("qqq_done", 0, 0, 0, 0, 0, 0, 6'd0);

        // Q, Q, N then cancel: quarter, quarter, nickel.
        coin_sel = 2'b10; step();
        coin_sel = 2'b11; step();
        coin_sel = 2'b10; step();
        coin_sel = 2'b11; step();
        coin_sel = 2'b00; step(); chk("qqn_credit", 0, 0, 0, 0, 0, 0, 6'd11);
        coin_sel = 2'b11; cancel = 1'b1;
        step();               chk("refund_q1", 0, 0, 0, 1, 1, 0, 6'd11);
        cancel = 1'b0;
        step();               chk("refund_q2", 0, 0, 0, 1, 1, 0, 6'd6);
        step();               chk("refund_n", 0, 1, 0, 0, 1, 0, 6'd1);
        step();               chk("refund_done", 0, 0, 0, 0, 0, 0, 6'd0);

        // Coin edge during change is rejected, and the held code is not counted later.
        coin_sel = 2'b10; step();
        coin_sel = 2'b11; step();
        coin_sel = 2'b10; step(); chk("busy_setup", 0, 0, 0, 0, 0, 0, 6'd10);
        coin_sel = 2'b11; cancel = 1'b1;
        step();               chk("busy_q1", 0, 0, 0, 1, 1, 0, 6'd10);
        cancel = 1'b0; coin_sel = 2'b01;
        step();               chk("busy_reject", 0, 0, 0, 1, 1, 1, 6'd5);
        step();               chk("busy_done", 0, 0, 0, 0, 0, 0, 6'd0);
        step();               chk("busy_held", 0, 0, 0, 0, 0, 0, 6'd0);
        coin_sel = 2'b11; step();

        // Reset in the middle of a refund.
        coin_sel = 2'b10; step();
        coin_sel = 2'b11; step();
        coin_sel = 2'b10; step();
        coin_sel = 2'b11; cancel = 1'b1;
        step();               chk("rst_pre", 0, 0, 0, 1, 1, 0, 6'd10);
        cancel = 1'b0;
        rst_n  = 1'b0;
        #1;                   chk("rst_async", 0, 0, 0, 0, 0, 0, 6'd0);
        step();
        rst_n = 1'b1;
        step();               chk("rst_after1", 0, 0, 0, 0, 0, 0, 6'd0);
        step();               chk("rst_after2", 0, 0, 0, 0, 0, 0, 6'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
